// File: rtl/ser_rx_ctrl.sv
// Serial-to-parallel receiver: synchronizes an external serial clock, data and frame enable,
// assembles MSB-first words and hands them off with valid/ready. Define SER_RX_PARITY_EN for a trailing even-parity bit.
module ser_rx_ctrl #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             serclk,
  input  logic             ser_in,
  input  logic             frame_n,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             ovr_clr,
  output logic             overrun,
  output logic             frame_err,
  output logic             par_err,
  output logic             busy
);

  localparam int unsigned      CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

`ifdef SER_RX_PARITY_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } state_t;
`else
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;
`endif

  state_t r_state;
  state_t w_state_nxt;

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_sin_sync;
  logic [SYNC_STAGES-1:0] r_frm_sync;
  logic                   r_sclk_prev;
  logic                   w_sclk;
  logic                   w_sin;
  logic                   w_frm;
  logic                   w_edge;

  logic [CNT_W-1:0]       r_cnt;
  logic [WIDTH-1:0]       r_store;
  logic [WIDTH-1:0]       w_shift_val;
  logic [WIDTH-1:0]       w_word;

  logic                   w_cnt_clr;
  logic                   w_cnt_inc;
  logic                   w_shift_en;
  logic                   w_store_clr;
  logic                   w_complete;
  logic                   w_frame_err_nxt;
  logic                   w_par_nxt;
  logic                   w_accept;
  logic                   w_drop;

  logic [WIDTH-1:0]       r_out_data;
  logic                   r_out_valid;
  logic                   r_overrun;
  logic                   r_frame_err;
  logic                   r_par_err;
  logic                   r_busy;

  // Input synchronizers, reset to the idle line levels
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sclk_sync <= '1;
      r_sin_sync  <= '0;
      r_frm_sync  <= '1;
      r_sclk_prev <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], serclk};
      r_sin_sync  <= {r_sin_sync[SYNC_STAGES-2:0], ser_in};
      r_frm_sync  <= {r_frm_sync[SYNC_STAGES-2:0], frame_n};
      r_sclk_prev <= w_sclk;
    end
  end

  assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
  assign w_sin       = r_sin_sync[SYNC_STAGES-1];
  assign w_frm       = r_frm_sync[SYNC_STAGES-1];
  assign w_edge      = r_sclk_prev & ~w_sclk;
  assign w_shift_val = WIDTH'({r_store, w_sin});

`ifdef SER_RX_PARITY_EN
  assign w_word = r_store;
`else
  assign w_word = w_shift_val;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and per-cycle control strobes
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_clr       = 1'b0;
    w_cnt_inc       = 1'b0;
    w_shift_en      = 1'b0;
    w_store_clr     = 1'b0;
    w_complete      = 1'b0;
    w_frame_err_nxt = 1'b0;
    w_par_nxt       = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_frm) begin
          w_state_nxt = SHIFT;
          w_cnt_clr   = 1'b1;
          w_store_clr = 1'b1;
        end
      end
      SHIFT: begin
        if (w_frm) begin
          w_state_nxt     = IDLE;
          w_cnt_clr       = 1'b1;
          w_store_clr     = 1'b1;
          w_frame_err_nxt = (r_cnt != '0);
        end else if (w_edge) begin
          w_shift_en = 1'b1;
          if (r_cnt == LAST_BIT) begin
            w_cnt_clr = 1'b1;
`ifdef SER_RX_PARITY_EN
            w_state_nxt = PAR;
`else
            w_complete  = 1'b1;
`endif
          end else begin
            w_cnt_inc = 1'b1;
          end
        end
      end
`ifdef SER_RX_PARITY_EN
      // Full data word is held in r_store; the next bit is the parity bit
      PAR: begin
        if (w_frm) begin
          w_state_nxt     = IDLE;
          w_cnt_clr       = 1'b1;
          w_store_clr     = 1'b1;
          w_frame_err_nxt = 1'b1;
        end else if (w_edge) begin
          w_state_nxt = SHIFT;
          w_complete  = 1'b1;
          w_par_nxt   = (^r_store) ^ w_sin;
        end
      end
`endif
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_store <= '0;
      r_cnt   <= '0;
    end else begin
      if (w_store_clr) begin
        r_store <= '0;
      end else if (w_shift_en) begin
        r_store <= w_shift_val;
      end
      if (w_cnt_clr) begin
        r_cnt <= '0;
      end else if (w_cnt_inc) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  // A completing word is dropped only when the previous one is still pending and not being taken
  assign w_accept = r_out_valid & out_ready;
  assign w_drop   = w_complete & r_out_valid & ~out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
      r_par_err   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      if (w_complete && !w_drop) begin
        r_out_data  <= w_word;
        r_out_valid <= 1'b1;
        r_par_err   <= w_par_nxt;
      end else if (w_accept) begin
        r_out_valid <= 1'b0;
      end
      if (w_drop) begin
        r_overrun <= 1'b1;
      end else if (ovr_clr) begin
        r_overrun <= 1'b0;
      end
      r_frame_err <= w_frame_err_nxt;
      r_busy      <= (w_state_nxt != IDLE);
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign overrun   = r_overrun;
  assign frame_err = r_frame_err;
  assign par_err   = r_par_err;
  assign busy      = r_busy;

endmodule

// File: tb/tb_ser_rx_ctrl.sv
// Scoreboard bench for ser_rx_ctrl: serial stimulus on negedges, outputs sampled on negedges,
// expected {par_err, out_data} queued at drive time and popped on each handshake.
module tb_ser_rx_ctrl;
  localparam int unsigned WIDTH = 8;
`ifdef SER_RX_PARITY_EN
  localparam int NB = WIDTH + 1;
`else
  localparam int NB = WIDTH;
`endif

  logic             clk       = 1'b0;
  logic             reset     = 1'b0;
  logic             serclk    = 1'b1;
  logic             ser_in    = 1'b0;
  logic             frame_n   = 1'b1;
  logic             out_ready = 1'b0;
  logic             ovr_clr   = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             overrun;
  logic             frame_err;
  logic             par_err;
  logic             busy;

  int checks  = 0;
  int errors  = 0;
  int n_valid = 0;
  int n_ferr  = 0;
  logic [WIDTH:0] exp_q[$];

  ser_rx_ctrl #(.WIDTH(WIDTH), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .serclk(serclk), .ser_in(ser_in), .frame_n(frame_n),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .ovr_clr(ovr_clr),
    .overrun(overrun), .frame_err(frame_err), .par_err(par_err), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "timeout");
  end

  // Advance to the next negedge; scoreboard every handshake seen there
  task automatic tick();
    logic [WIDTH:0] e;
    @(negedge clk);
    if (reset) begin
      if (out_valid) n_valid++;
      if (frame_err) n_ferr++;
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected got data=%h, none expected", out_data);
        end else begin
          e = exp_q.pop_front();
          if ({par_err, out_data} !== e) begin
            errors++;
            $display("FAIL sb_word got par=%b data=%h, expected par=%b data=%h",
                     par_err, out_data, e[WIDTH], e[WIDTH-1:0]);
          end
        end
      end
    end
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) tick();
  endtask

  // Present a bit with serclk high, then drop serclk (falling edge lands on a negedge)
  task automatic drive_bit(input logic b);
    serclk = 1'b1;
    ser_in = b;
    wait_ticks(4);
    serclk = 1'b0;
  endtask

  task automatic send_bits(input logic [WIDTH:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      drive_bit(v[i]);
      wait_ticks(4);
    end
  endtask

  function automatic logic [WIDTH:0] word_bits(input logic [WIDTH-1:0] w);
`ifdef SER_RX_PARITY_EN
    return {w, ^w};
`else
    return {1'b0, w};
`endif
  endfunction

  task automatic send_word(input logic [WIDTH-1:0] w);
    send_bits(word_bits(w), NB);
  endtask

  task automatic frame_start();
    frame_n = 1'b0;
    serclk  = 1'b1;
    wait_ticks(4);
  endtask

  task automatic frame_end();
    frame_n = 1'b1;
    serclk  = 1'b1;
    wait_ticks(6);
  endtask

  task automatic set_ready(input logic b);
    @(posedge clk);
    #1 out_ready = b;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({out_data, out_valid, overrun, frame_err, par_err, busy} !== '0) begin
      errors++;
      $display("FAIL reset_state got data=%h v=%b ovr=%b fe=%b pe=%b busy=%b, expected all 0",
               out_data, out_valid, overrun, frame_err, par_err, busy);
    end
    wait_ticks(3);
    reset = 1'b1;
    wait_ticks(3);
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got busy=%b valid=%b, expected 0 0", busy, out_valid);
    end
  endtask

  task automatic test_basic();
    logic [WIDTH:0] v;
    int nv0;
    set_ready(1'b1);
    frame_start();
    exp_q.push_back({1'b0, 8'hA5});
    v   = word_bits(8'hA5);
    nv0 = n_valid;
    send_bits(v >> 1, NB - 1);
    drive_bit(v[0]);
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_early got valid=%b, expected 0", out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hA5) begin
      errors++;
      $display("FAIL basic_latency got valid=%b data=%h, expected 1 a5", out_valid, out_data);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_one_cycle got valid=%b, expected 0", out_valid);
    end
    frame_end();
    checks++;
    if (n_valid - nv0 != 1) begin
      errors++;
      $display("FAIL basic_valid_count got %0d, expected 1", n_valid - nv0);
    end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] w;
    set_ready(1'b1);
    frame_start();
    for (int i = 0; i < 6; i++) begin
      w = (i < 3) ? WIDTH'(8'h12 + 8'h22 * i) : WIDTH'($urandom);
      exp_q.push_back({1'b0, w});
      send_word(w);
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_busy got %b, expected 1", busy);
    end
    frame_end();
    checks++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drained got pending=%0d busy=%b, expected 0 0", exp_q.size(), busy);
    end
  endtask

  task automatic test_overrun();
    logic [WIDTH:0] v;
    set_ready(1'b0);
    frame_start();
    exp_q.push_back({1'b0, 8'h3C});
    send_word(8'h3C);
    send_word(8'hC3);
    checks++;
    if (out_data !== 8'h3C || out_valid !== 1'b1 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL ovr_set got data=%h v=%b ovr=%b, expected 3c 1 1", out_data, out_valid, overrun);
    end
    @(posedge clk);
    #1 ovr_clr = 1'b1;
    tick();
    @(posedge clk);
    #1 ovr_clr = 1'b0;
    tick();
    checks++;
    if (overrun !== 1'b0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL ovr_clear got ovr=%b v=%b, expected 0 1", overrun, out_valid);
    end
    exp_q.push_back({1'b0, 8'h5A});
    v = word_bits(8'h5A);
    send_bits(v >> 1, NB - 1);
    drive_bit(v[0]);
    tick();
    @(posedge clk);
    #1 out_ready = 1'b1;
    tick();
    tick();
    checks++;
    if (out_data !== 8'h5A || out_valid !== 1'b1 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL ovr_simul got data=%h v=%b ovr=%b, expected 5a 1 0", out_data, out_valid, overrun);
    end
    wait_ticks(2);
    frame_end();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL ovr_drained got pending=%0d, expected 0", exp_q.size());
    end
  endtask

  task automatic test_frame_err();
    int ne0;
    int nv0;
    set_ready(1'b1);
    ne0 = n_ferr;
    nv0 = n_valid;
    frame_start();
    send_bits(9'b101, 3);
    frame_end();
    checks++;
    if (n_ferr - ne0 != 1 || n_valid != nv0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ferr_pulse got pulses=%0d valids=%0d busy=%b, expected 1 0 0",
               n_ferr - ne0, n_valid - nv0, busy);
    end
    frame_start();
    exp_q.push_back({1'b0, 8'h0F});
    send_word(8'h0F);
    frame_end();
    checks++;
    if (out_data !== 8'h0F || n_ferr - ne0 != 1) begin
      errors++;
      $display("FAIL ferr_recover got data=%h pulses=%0d, expected 0f 1", out_data, n_ferr - ne0);
    end
  endtask

  task automatic test_reset_mid();
    set_ready(1'b1);
    frame_start();
    send_bits(9'b10110, 5);
    tick();
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({out_data, out_valid, overrun, frame_err, par_err, busy} !== '0) begin
      errors++;
      $display("FAIL rst_async got data=%h v=%b ovr=%b fe=%b pe=%b busy=%b, expected all 0",
               out_data, out_valid, overrun, frame_err, par_err, busy);
    end
    serclk = 1'b1;
    ser_in = 1'b0;
    wait_ticks(3);
    reset = 1'b1;
    wait_ticks(4);
    exp_q.push_back({1'b0, 8'h81});
    send_word(8'h81);
    frame_end();
    checks++;
    if (out_data !== 8'h81 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL rst_recover got data=%h pending=%0d, expected 81 0", out_data, exp_q.size());
    end
  endtask

`ifdef SER_RX_PARITY_EN
  task automatic test_parity();
    int ne0;
    set_ready(1'b1);
    frame_start();
    exp_q.push_back({1'b0, 8'h07});
    send_bits({8'h07, 1'b1}, NB);
    exp_q.push_back({1'b1, 8'h07});
    send_bits({8'h07, 1'b0}, NB);
    frame_end();
    checks++;
    if (par_err !== 1'b1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL par_bad got par=%b pending=%0d, expected 1 0", par_err, exp_q.size());
    end
    ne0 = n_ferr;
    frame_start();
    send_bits({1'b0, 8'h07}, WIDTH);
    frame_end();
    checks++;
    if (n_ferr - ne0 != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL par_ferr got pulses=%0d busy=%b, expected 1 0", n_ferr - ne0, busy);
    end
  endtask
`else
  task automatic test_parity();
    checks++;
    if (par_err !== 1'b0) begin
      errors++;
      $display("FAIL par_const got %b, expected 0", par_err);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_overrun();
    test_frame_err();
    test_reset_mid();
    test_parity();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
